dsp_sd_dac: RTL and testbench
=============================

Name: dsp_sd_dac

Overview:
First-order sigma-delta DAC output stage sitting directly downstream of DSP48. It accepts signed PCM samples from DSP48 over a valid/ready stream and buffers them in a small FIFO. It releases one sample per programmable oversampling period and modulates it into a 1-bit pulse-density stream driven onto a user io_out pad. Underrun, FIFO level and pad output-enable are exposed for the wrapper and Wishbone status.

Parameters:
DW, 16, sample width (signed two's complement)
OSR_W, 8, width of oversampling-period register
FIFO_DEPTH, 4, sample FIFO entries (power of two)

Ports:
wb_clk_i  input  1  single clock for the whole block
wb_rst_ni  input  1  asynchronous, active-low reset
enable_i  input  1  modulator enable (level)
osr_i  input  OSR_W  sample period minus 1, in clocks
s_valid_i  input  1  upstream sample valid
s_data_i  input  DW  upstream sample, signed
s_ready_o  output  1  FIFO can accept (= not full)
dac_o  output  1  pulse-density output bit (to io_out)
dac_oeb_o  output  1  pad output-enable, active-low
underrun_o  output  1  sticky: sample period elapsed with FIFO empty
clr_underrun_i  input  1  clears underrun_o
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_level_o=0, s_ready_o=1, dac_o=0, dac_oeb_o=1, underrun_o=0, tick counter=0, accumulator=0, cur_sample=0 (midscale), primed=0.
- Push: handshake when s_valid_i && s_ready_o. s_ready_o = registered count != FIFO_DEPTH. No combinational path from s_valid_i to s_ready_o. The FIFO accepts pushes whether or not enable_i is high.
- Tick counter, enable_i=1: increments each clock. When cnt >= osr_i: tick, cnt<=0. Using >= makes a mid-period reduction of osr_i safe. Period = osr_i+1 clocks; the first tick comes osr_i+1 clocks after enable rises.
- On tick with FIFO non-empty: pop head into cur_sample, set primed=1.
- On tick with FIFO empty: hold cur_sample. If primed=1, set underrun_o (visible the next cycle). If primed=0, no underrun.
- Push and pop in the same cycle: both take effect and the level is unchanged. When the FIFO is empty, a same-cycle push is not bypassed: the pop sees empty and the pushed data is stored.
- clr_underrun_i clears underrun_o. If a set and a clear land in the same cycle, the set wins.
- Modulator, every clock while enable_i=1:
  - u = cur_sample with its MSB inverted (offset binary).
  - acc_next = {1'b0, acc[DW-1:0]} + u, a DW+1-bit value.
  - acc <= acc_next; dac_o <= acc_next[DW].
  - Ones density = u / 2^DW.
  - A new cur_sample affects dac_o from the clock after it is loaded.
- enable_i=0:
  - Cleared on the next clock: cnt, acc, dac_o, primed, and cur_sample (midscale).
  - dac_oeb_o <= 1. dac_oeb_o <= 0 one clock after enable_i rises.
  - FIFO contents and underrun_o are preserved.
- Reset mid-operation discards FIFO contents and returns every output to its reset value immediately.

Decomposition:
- Package dsp_dac_pkg:
  - DW, OSR_W, FIFO_DEPTH defaults
  - MIDSCALE constant (0)
  - sample_t typedef (logic signed [DW-1:0])
- Sub-module dsp_dac_fifo: synchronous FIFO with pointers, count and full/empty, same clock/reset.
- dsp_sd_dac holds the tick counter, underrun logic and the modulator.

Test Plan:
1. Reset checks: assert wb_rst_ni=0 asynchronously mid-cycle → immediately dac_o=0, dac_oeb_o=1, s_ready_o=1, underrun_o=0, fifo_level_o=0.
2. FIFO full with enable_i=0: offer 5 back-to-back samples → 4 accepted, s_ready_o=0 after the 4th, fifo_level_o=4, 5th held until a pop.
3. Midscale: push 0x0000, osr_i=3, enable → after the sample loads, dac_o alternates 0,1,0,1… (u=0x8000).
4. Density: push 0x4000 repeatedly, osr_i=255, count dac_o ones over 65536 clocks after the first load → 49152 ±1.
5. Underrun: osr_i=3, push one sample, enable → first tick loads it, second tick finds FIFO empty → underrun_o=1 the next cycle and cur_sample is held. Assert clr_underrun_i in the same cycle as a third empty tick → underrun_o stays 1.
6. Disable/re-enable: stream at osr_i=7, drop enable_i for 10 clocks → dac_o=0, dac_oeb_o=1, fifo_level_o unchanged. Re-enable → dac_oeb_o=0 after 1 clock and first pop after 8 clocks.

Source files
------------

// File: rtl/dsp_dac_pkg.sv
// Shared defaults and sample type for the sigma-delta DAC output stage.
package dsp_dac_pkg;
  localparam int DEF_DW         = 16;
  localparam int DEF_OSR_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic signed [DEF_DW-1:0] sample_t;

  // Signed zero sits at the middle of the offset-binary output range.
  localparam sample_t MIDSCALE = '0;
endpackage

// File: rtl/dsp_dac_fifo.sv
// Small synchronous sample FIFO; registered count drives full/empty.
module dsp_dac_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/dsp_sd_dac.sv
// First-order sigma-delta DAC: FIFO-buffered PCM in, 1-bit pulse-density out.
module dsp_sd_dac
  import dsp_dac_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int OSR_W      = DEF_OSR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic                          enable_i,
  input  logic [OSR_W-1:0]              osr_i,
  input  logic                          s_valid_i,
  input  logic [DW-1:0]                 s_data_i,
  output logic                          s_ready_o,
  output logic                          dac_o,
  output logic                          dac_oeb_o,
  output logic                          underrun_o,
  input  logic                          clr_underrun_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  logic [DW-1:0]        head;
  logic                 full, empty;
  logic [OSR_W-1:0]     cnt;
  logic                 tick;
  logic signed [DW-1:0] cur;
  logic                 primed;
  logic [DW-1:0]        acc, u;
  logic [DW:0]          acc_next;

  dsp_dac_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (s_valid_i),
    .din   (s_data_i),
    .pop   (tick),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_level_o)
  );

  assign s_ready_o = !full;
  // >= rather than == so lowering osr_i mid-period cannot skip a tick.
  assign tick      = enable_i && (cnt >= osr_i);
  assign u         = {~cur[DW-1], cur[DW-2:0]};
  assign acc_next  = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt       <= '0;
      acc       <= '0;
      dac_o     <= 1'b0;
      dac_oeb_o <= 1'b1;
      cur       <= DW'(MIDSCALE);
      primed    <= 1'b0;
    end else if (!enable_i) begin
      cnt       <= '0;
      acc       <= '0;
      dac_o     <= 1'b0;
      dac_oeb_o <= 1'b1;
      cur       <= DW'(MIDSCALE);
      primed    <= 1'b0;
    end else begin
      dac_oeb_o <= 1'b0;
      acc       <= acc_next[DW-1:0];
      dac_o     <= acc_next[DW];
      cnt       <= tick ? '0 : cnt + OSR_W'(1);
      if (tick && !empty) begin
        cur    <= $signed(head);
        primed <= 1'b1;
      end
    end
  end

  // Underrun only counts once real data has flowed; set beats clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                  underrun_o <= 1'b0;
    else if (tick && empty && primed) underrun_o <= 1'b1;
    else if (clr_underrun_i)          underrun_o <= 1'b0;
  end
endmodule

// File: tb/tb_dsp_sd_dac.sv
// Scoreboarded bench: a queue/integer reference model predicts every cycle's outputs.
module tb_dsp_sd_dac;
  localparam int DEPTH = 4;

  logic        wb_clk_i = 1'b0, wb_rst_ni = 1'b0, enable_i = 1'b0;
  logic        s_valid_i = 1'b0, clr_underrun_i = 1'b0;
  logic [7:0]  osr_i = '0;
  logic [15:0] s_data_i = '0;
  logic        s_ready_o, dac_o, dac_oeb_o, underrun_o;
  logic [2:0]  fifo_level_o;

  int vectors = 0, miscompares = 0, ones = 0;

  typedef struct {
    logic [6:0] outs;   // {dac, oeb, underrun, ready, level[2:0]}
    bit         cnt_it;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  int m_q[$];
  int m_cnt, m_acc, m_cur;
  bit m_dac, m_oeb, m_und, m_primed;

  dsp_sd_dac dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_ni     (wb_rst_ni),
    .enable_i      (enable_i),
    .osr_i         (osr_i),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .dac_o         (dac_o),
    .dac_oeb_o     (dac_oeb_o),
    .underrun_o    (underrun_o),
    .clr_underrun_i(clr_underrun_i),
    .fifo_level_o  (fifo_level_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_acc = 0; m_cur = 0;
    m_dac = 0; m_oeb = 1; m_und = 0; m_primed = 0;
  endtask

  // One clock edge of the DAC described from its rules, in plain arithmetic.
  task automatic model_edge(input bit en, input int osr, input bit v, input logic [15:0] d,
                            input bit clr);
    bit push, tick, pop, set;
    int sum, sd;
    push = v && (m_q.size() < DEPTH);
    tick = en && (m_cnt >= osr);
    pop  = tick && (m_q.size() > 0);
    set  = tick && (m_q.size() == 0) && m_primed;
    if (en) begin
      sum   = m_acc + (m_cur + 32768);
      m_dac = (sum >= 65536);
      m_acc = sum % 65536;
      m_cnt = tick ? 0 : m_cnt + 1;
      m_oeb = 0;
      if (pop) begin
        m_cur    = m_q.pop_front();
        m_primed = 1;
      end
    end else begin
      m_cnt = 0; m_acc = 0; m_dac = 0; m_cur = 0; m_primed = 0; m_oeb = 1;
    end
    if (push) begin
      sd = $signed(d);
      m_q.push_back(sd);
    end
    m_und = set ? 1'b1 : (clr ? 1'b0 : m_und);
  endtask

  task automatic step(input bit en, input logic [7:0] osr, input bit v, input logic [15:0] d,
                      input bit clr, input bit cnt_it = 0);
    exp_t e;
    int   lvl;
    @(negedge wb_clk_i);
    enable_i = en; osr_i = osr; s_valid_i = v; s_data_i = d; clr_underrun_i = clr;
    model_edge(en, int'(osr), v, d, clr);
    lvl = m_q.size();
    e.outs   = {m_dac, m_oeb, m_und, (lvl != DEPTH), 3'(lvl)};
    e.cnt_it = cnt_it;
    sbq.push_back(e);
  endtask

  task automatic settle();
    @(posedge wb_clk_i);
    #2;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must collapse at once.
  task automatic do_reset();
    settle();
    wb_rst_ni = 1'b0;
    enable_i = 0; s_valid_i = 0; clr_underrun_i = 0;
    #1;
    chk("rst_dac", dac_o, 0);
    chk("rst_oeb", dac_oeb_o, 1);
    chk("rst_ready", s_ready_o, 1);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_level", fifo_level_o, 0);
    model_reset();
    @(posedge wb_clk_i);
    #3 wb_rst_ni = 1'b1;
  endtask

  // Monitor: compares each predicted cycle against the DUT after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        if ({dac_o, dac_oeb_o, underrun_o, s_ready_o, fifo_level_o} !== e.outs) begin
          miscompares++;
          $display("FAIL sb {dac,oeb,und,rdy,lvl} got %b expected %b (t=%0t)",
                   {dac_o, dac_oeb_o, underrun_o, s_ready_o, fifo_level_o}, e.outs, $time);
        end
        if (e.cnt_it && dac_o === 1'b1) ones++;
      end
    end
  end

  initial begin
    int counted, guard;
    bit c;
    model_reset();
    do_reset();

    // FIFO fill while disabled: 4 accepted, 5th held, then drained by ticks
    for (int i = 0; i < 5; i++) step(0, 3, 1, 16'h1000 + 16'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 3, 1, 16'h1004, 0);
    settle();
    chk("full_level", fifo_level_o, 4);
    chk("full_ready", s_ready_o, 0);
    for (int i = 0; i < 6; i++) step(1, 3, 1, 16'h1004, 0);
    for (int i = 0; i < 12; i++) step(1, 3, 0, 16'h0, 0);

    // Midscale sample gives a 0,1,0,1 pattern
    do_reset();
    step(0, 3, 1, 16'h0000, 0);
    for (int i = 0; i < 20; i++) step(1, 3, 0, 16'h0, 0);

    // Underrun: one sample, second tick empty, clear colliding with third tick
    do_reset();
    step(0, 3, 1, 16'h1234, 0);
    for (int k = 1; k <= 16; k++) step(1, 3, 0, 16'h0, (k == 12));
    settle();
    chk("underrun_sticky", underrun_o, 1);
    step(1, 3, 0, 16'h0, 1);
    settle();
    chk("underrun_clr", underrun_o, 0);

    // Disable/re-enable while streaming at osr=7
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 7, ($urandom_range(1) == 1), 16'($urandom), 0);
    for (int i = 0; i < 10; i++) step(0, 7, 0, 16'h0, 0);
    for (int i = 0; i < 30; i++) step(1, 7, ($urandom_range(1) == 1), 16'($urandom), 0);

    // Randomized traffic, including osr changes mid-period
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(9) != 0), 8'($urandom_range(7)), ($urandom_range(2) != 0),
           16'($urandom), ($urandom_range(19) == 0));

    // Density: 0x4000 -> u=0xC000 -> 3/4 ones over 65536 clocks after first load
    do_reset();
    counted = 0; guard = 0;
    while (counted < 65536 && guard < 70000) begin
      c = m_primed;
      step(1, 8'd255, 1, 16'h4000, 0, c);
      if (c) counted++;
      guard++;
    end
    settle();
    settle();
    vectors++;
    if (ones < 49151 || ones > 49153) begin
      miscompares++;
      $display("FAIL density: ones=%0d, expected 49152 +/-1", ones);
    end
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
